// File: rtl/rs_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// rs_frame_sequencer: streams one RS(15,11) codeword into a serial syndrome unit,
// collects the returned syndromes and presents them on a valid/ready port.
module rs_frame_sequencer #(
  parameter int NSYM    = 15,
  parameter int NSYN    = 4,
  parameter int SYN_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_symbol,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        syn_in_serial,
  output logic [3:0]        syn_control,
  input  logic [3:0]        syn_out_serial,
  output logic [4*NSYN-1:0] syn_data,
  output logic              syn_valid,
  input  logic              syn_ready,
  output logic              err_flag,
  output logic              frame_abort
);

  localparam int KW = (NSYN > 1) ? $clog2(NSYN) : 1;
  localparam int LW = $clog2(SYN_LAT + 1);
  localparam logic [3:0] CTL_ACCUM = 4'hF;
  localparam logic [3:0] CTL_DUMP  = 4'h0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    DUMP    = 3'd2,
    WAIT    = 3'd3,
    COLLECT = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t            r_state;
  logic [3:0]        r_scnt;
  logic [KW-1:0]     r_kcnt;
  logic [LW-1:0]     r_lcnt;
  logic              w_accepting;
  logic              w_xfer;
  logic [4*NSYN-1:0] w_syn_next;

  // Gating with rst_n keeps every output at its reset value while reset is held.
  always_comb begin
    w_accepting   = rst_n && (r_state == IDLE || r_state == ACCUM);
    w_xfer        = w_accepting && in_valid;
    in_ready      = w_accepting;
    syn_in_serial = w_xfer ? in_symbol : 4'h0;
    syn_control   = w_xfer ? CTL_ACCUM : CTL_DUMP;
    frame_abort   = rst_n && (r_state == ACCUM) && !in_valid;
    w_syn_next    = syn_data;
    w_syn_next[{r_kcnt, 2'b00} +: 4] = syn_out_serial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_scnt    <= '0;
      r_kcnt    <= '0;
      r_lcnt    <= '0;
      syn_data  <= '0;
      syn_valid <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state <= ACCUM;
            r_scnt  <= 4'd1;
          end
        end
        ACCUM: begin
          if (!in_valid) begin
            r_state <= IDLE;
            r_scnt  <= '0;
          end else if (r_scnt == 4'(NSYM - 1)) begin
            r_state  <= DUMP;
            r_scnt   <= '0;
            syn_data <= '0;
            err_flag <= 1'b0;
          end else begin
            r_scnt <= r_scnt + 4'd1;
          end
        end
        DUMP: begin
          r_kcnt  <= '0;
          r_lcnt  <= LW'(SYN_LAT - 1);
          r_state <= (SYN_LAT > 1) ? WAIT : COLLECT;
        end
        WAIT: begin
          r_lcnt <= r_lcnt - LW'(1);
          if (r_lcnt == LW'(1)) begin
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          syn_data <= w_syn_next;
          r_kcnt   <= r_kcnt + KW'(1);
          if (r_kcnt == KW'(NSYN - 1)) begin
            r_state   <= HOLD;
            syn_valid <= 1'b1;
            err_flag  <= |w_syn_next;
          end
        end
        HOLD: begin
          if (syn_ready) begin
            syn_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
